// File: rtl/ram_wb_burst_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_wb_pkg
// Purpose  : Shared Wishbone burst constants and master state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package ram_wb_pkg;

  // Cycle type identifiers driven on wb cti
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Burst type extension: linear incrementing only
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_wb_burst_master_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_wb_burst_master_if
// Purpose  : Wishbone B3 bus bundle between the burst master and RAM slave.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_wb_burst_master_if #(
  parameter int ADR_WIDTH = 16
);

  logic [ADR_WIDTH-3:0] adr;     // word address
  logic [31:0]          dat_wr;  // master -> slave data
  logic [31:0]          dat_rd;  // slave -> master data
  logic                 we;
  logic [3:0]           sel;
  logic                 cyc;
  logic                 stb;
  logic [2:0]           cti;
  logic [1:0]           bte;
  logic                 ack;

  modport master (
    output adr, dat_wr, we, sel, cyc, stb, cti, bte,
    input  dat_rd, ack
  );

  modport slave (
    input  adr, dat_wr, we, sel, cyc, stb, cti, bte,
    output dat_rd, ack
  );

endinterface
`default_nettype wire

// File: rtl/ram_wb_burst_master_cnt.sv
`default_nettype none
// ============================================================================
// Module   : ram_wb_burst_cnt
// Purpose  : Burst word-address / remaining-beat counter. The address wraps
//            silently modulo the word-address space; the remaining count
//            saturates at zero so a stray step after the last beat is benign.
// Revision : 1.0 - initial release
// ============================================================================
module ram_wb_burst_cnt #(
  parameter int ADR_WIDTH = 16,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [ADR_WIDTH-3:0] adr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 step_i,
  output logic [ADR_WIDTH-3:0] adr_o,
  output logic                 last_o
);

  localparam logic [ADR_WIDTH-3:0] c_adr_one = {{(ADR_WIDTH-3){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0] c_len_one = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  logic [ADR_WIDTH-3:0] r_adr;
  logic [LEN_WIDTH-1:0] r_rem;

  // Load on command accept, advance on every acknowledged beat
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_adr <= '0;
      r_rem <= '0;
    end else if (load_i) begin
      r_adr <= adr_i;
      r_rem <= len_i;
    end else if (step_i) begin
      r_adr <= r_adr + c_adr_one;
      if (r_rem != '0) begin
        r_rem <= r_rem - c_len_one;
      end
    end
  end

  assign adr_o  = r_adr;
  assign last_o = (r_rem == '0);

endmodule
`default_nettype wire

// File: rtl/ram_wb_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : ram_wb_burst_master
// Purpose  : Wishbone B3 master issuing one linear incrementing burst per
//            command. Write words enter through a one-word holding register;
//            read words leave as a registered one-cycle strobe.
// Revision : 1.0 - initial release
// ============================================================================
module ram_wb_burst_master
  import ram_wb_pkg::*;
#(
  parameter int ADR_WIDTH = 16,
  parameter int LEN_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  // command channel
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_we_i,
  input  logic [ADR_WIDTH-3:0]   cmd_adr_i,
  input  logic [LEN_WIDTH-1:0]   cmd_len_i,
  // write data stream
  input  logic [31:0]            wdat_i,
  input  logic                   wdat_valid_i,
  output logic                   wdat_ready_o,
  // read data stream
  output logic [31:0]            rdat_o,
  output logic                   rdat_valid_o,
  // status
  output logic                   done_o,
  output logic                   busy_o,
  // Wishbone bus
  ram_wb_burst_master_if.master  wb
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_cmd_take;

  logic                 r_we;
  logic                 r_single;
  logic                 r_hold_full;
  logic [31:0]          r_hold_dat;
  logic                 r_rdat_valid;
  logic [31:0]          r_rdat;

  logic                 w_in_burst;
  logic                 w_stb;
  logic                 w_beat;
  logic                 w_wload;
  logic                 w_last;
  logic [ADR_WIDTH-3:0] w_adr;
  logic [2:0]           w_cti;

  assign w_in_burst = (r_state == BURST);
  // A write beat can only be offered once its data word is held
  assign w_stb      = w_in_burst & (~r_we | r_hold_full);
  assign w_beat     = w_stb & wb.ack;
  assign w_wload    = wdat_valid_i & wdat_ready_o;

  ram_wb_burst_cnt #(
    .ADR_WIDTH (ADR_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (w_cmd_take),
    .adr_i  (cmd_adr_i),
    .len_i  (cmd_len_i),
    .step_i (w_beat),
    .adr_o  (w_adr),
    .last_o (w_last)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and command acceptance
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_take  = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid_i) begin
          w_cmd_take  = 1'b1;
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        if (w_beat && w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latch burst direction and the single-beat flag at command accept
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we     <= 1'b0;
      r_single <= 1'b0;
    end else if (w_cmd_take) begin
      r_we     <= cmd_we_i;
      r_single <= (cmd_len_i == '0);
    end
  end

  // One-word write holding register; a same-cycle load wins over the ack
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hold_full <= 1'b0;
      r_hold_dat  <= '0;
    end else if (w_wload) begin
      r_hold_full <= 1'b1;
      r_hold_dat  <= wdat_i;
    end else if (w_beat && r_we) begin
      r_hold_full <= 1'b0;
    end
  end

  // Registered read data: one cycle after each read ack
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rdat_valid <= 1'b0;
      r_rdat       <= '0;
    end else begin
      r_rdat_valid <= w_beat & ~r_we;
      if (w_beat && !r_we) begin
        r_rdat <= wb.dat_rd;
      end
    end
  end

  // Cycle type follows the remaining count, so it is stable across waits
  always_comb begin
    w_cti = CTI_CLASSIC;
    if (w_in_burst && !r_single) begin
      w_cti = w_last ? CTI_EOB : CTI_INCR;
    end
  end

  assign cmd_ready_o  = (r_state == IDLE);
  assign busy_o       = w_in_burst;
  assign done_o       = (r_state == DONE);
  assign wdat_ready_o = w_in_burst & r_we & ~r_hold_full;
  assign rdat_o       = r_rdat;
  assign rdat_valid_o = r_rdat_valid;

  assign wb.adr    = w_adr;
  assign wb.dat_wr = r_hold_dat;
  assign wb.we     = w_in_burst & r_we;
  assign wb.sel    = 4'b1111;
  assign wb.cyc    = w_in_burst;
  assign wb.stb    = w_stb;
  assign wb.cti    = w_cti;
  assign wb.bte    = BTE_LINEAR;

endmodule
`default_nettype wire

// File: tb/tb_ram_wb_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_wb_burst_master
// Purpose  : Scoreboard bench for the Wishbone burst master with a RAM slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_wb_burst_master;

  localparam int AW = 16;
  localparam int LW = 8;

  typedef struct {
    logic [13:0] adr;
    logic [2:0]  cti;
    logic        we;
    logic [31:0] dat;
  } beat_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i, cmd_we_i;
  logic [13:0] cmd_adr_i;
  logic [7:0]  cmd_len_i;
  logic [31:0] wdat_i;
  logic        wdat_valid_i;
  logic        cmd_ready_o, wdat_ready_o, rdat_valid_o, done_o, busy_o;
  logic [31:0] rdat_o;

  ram_wb_burst_master_if #(.ADR_WIDTH(AW)) wb_bus ();

  ram_wb_burst_master #(.ADR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_we_i     (cmd_we_i),
    .cmd_adr_i    (cmd_adr_i),
    .cmd_len_i    (cmd_len_i),
    .wdat_i       (wdat_i),
    .wdat_valid_i (wdat_valid_i),
    .wdat_ready_o (wdat_ready_o),
    .rdat_o       (rdat_o),
    .rdat_valid_o (rdat_valid_o),
    .done_o       (done_o),
    .busy_o       (busy_o),
    .wb           (wb_bus)
  );

  always #5 clk_i = ~clk_i;

  int          total = 0;
  int          bad   = 0;
  beat_t       exp_beat[$];
  logic [31:0] exp_rd[$];
  int          exp_done = 0;
  logic [31:0] ram     [0:16383];
  logic [31:0] exp_mem [0:16383];
  bit          ack_en = 1'b1;
  bit          ack_wait = 1'b0;
  bit          feed_abort = 1'b0;
  int          mon_beats = 0;

  // RAM slave: combinational ack/read data, optional alternating wait states
  assign wb_bus.ack    = wb_bus.cyc & wb_bus.stb & ack_en;
  assign wb_bus.dat_rd = ram[wb_bus.adr];

  always @(posedge clk_i) ack_en <= ack_wait ? ~ack_en : 1'b1;

  always @(posedge clk_i)
    if (wb_bus.cyc && wb_bus.stb && wb_bus.ack && wb_bus.we)
      ram[wb_bus.adr] <= wb_bus.dat_wr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic fail_evt(input string nm);
    total++;
    bad++;
    $display("FAIL %s actual=event expected=none", nm);
  endtask

  // ---------------- monitor / scoreboard ----------------
  longint cyc_cnt = 0;
  longint last_done = -100;
  logic   prev_cyc = 1'b0, prev_beat = 1'b0, prev_rd_beat = 1'b0;
  logic [2:0] prev_cti = 3'b000;
  beat_t  mon_e;
  logic   beat;

  always @(negedge clk_i) begin
    cyc_cnt++;
    beat = wb_bus.cyc & wb_bus.stb & wb_bus.ack;
    if (rst_i) begin
      prev_cyc = 1'b0; prev_beat = 1'b0; prev_rd_beat = 1'b0;
    end else begin
      if (beat) begin
        mon_beats++;
        if (exp_beat.size() == 0) fail_evt("beat_unexpected");
        else begin
          mon_e = exp_beat.pop_front();
          chk("beat_adr", {18'd0, wb_bus.adr}, {18'd0, mon_e.adr});
          chk("beat_cti", {29'd0, wb_bus.cti}, {29'd0, mon_e.cti});
          chk("beat_we", {31'd0, wb_bus.we}, {31'd0, mon_e.we});
          if (mon_e.we) chk("beat_dat", wb_bus.dat_wr, mon_e.dat);
          chk("beat_sel", {28'd0, wb_bus.sel}, 32'hF);
          chk("beat_bte", {30'd0, wb_bus.bte}, 32'h0);
        end
      end
      if (rdat_valid_o || prev_rd_beat) begin
        chk("rdat_latency", {31'd0, rdat_valid_o}, {31'd0, prev_rd_beat});
        if (rdat_valid_o) begin
          if (exp_rd.size() == 0) fail_evt("rdat_unexpected");
          else chk("rdat", rdat_o, exp_rd.pop_front());
        end
      end
      if (done_o) begin
        chk("done_after_last_ack", {31'd0, prev_beat}, 32'd1);
        chk("done_busy_low", {31'd0, busy_o}, 32'd0);
        if (exp_done == 0) fail_evt("done_unexpected");
        else exp_done--;
        last_done = cyc_cnt;
      end
      if (wb_bus.cyc && !prev_cyc)
        chk("cmd_gap_ge2", {31'd0, (cyc_cnt - last_done) >= 2}, 32'd1);
      if (busy_o) chk("cyc_while_busy", {31'd0, wb_bus.cyc}, 32'd1);
      if (wb_bus.cyc && prev_cyc && !prev_beat)
        chk("cti_held", {29'd0, wb_bus.cti}, {29'd0, prev_cti});
      if (wb_bus.cyc && wb_bus.we && wdat_ready_o)
        chk("stb_low_hold_empty", {31'd0, wb_bus.stb}, 32'd0);
      if (!(wb_bus.cyc && wb_bus.we))
        chk("wdat_ready_outside_wr", {31'd0, wdat_ready_o}, 32'd0);
      if (busy_o || done_o)
        chk("cmd_ready_not_idle", {31'd0, cmd_ready_o}, 32'd0);
      prev_cyc     = wb_bus.cyc;
      prev_beat    = beat;
      prev_rd_beat = beat & ~wb_bus.we;
      prev_cti     = wb_bus.cti;
    end
  end

  // ---------------- stimulus helpers (called just after a negedge) ----------------
  task automatic push_exp(input bit we, input logic [13:0] adr, input int len,
                          input logic [31:0] base, input bit commit);
    beat_t b;
    for (int i = 0; i <= len; i++) begin
      b.adr = adr + 14'(i);
      b.we  = we;
      b.cti = (len == 0) ? 3'b000 : ((i == len) ? 3'b111 : 3'b010);
      b.dat = we ? base + 32'(i) : 32'h0;
      exp_beat.push_back(b);
      if (we) begin
        if (commit) exp_mem[b.adr] = b.dat;
      end else begin
        exp_rd.push_back(exp_mem[b.adr]);
      end
    end
    exp_done++;
  endtask

  task automatic issue_cmd(input bit we, input logic [13:0] adr, input int len);
    bit got;
    got = 1'b0;
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_len_i = 8'(len);
    for (int k = 0; k < 300 && !got; k++) begin
      if (cmd_ready_o) got = 1'b1;
      @(negedge clk_i);
    end
    if (!got) fail_evt("cmd_accept_timeout");
    cmd_valid_i = 1'b0;
  endtask

  task automatic feed(input logic [31:0] base, input int len, input bit toggle);
    bit got;
    for (int i = 0; i <= len && !feed_abort; i++) begin
      if (toggle) begin wdat_valid_i = 1'b0; @(negedge clk_i); end
      wdat_i = base + 32'(i);
      wdat_valid_i = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 300 && !got && !feed_abort; k++) begin
        if (wdat_ready_o) got = 1'b1;
        @(negedge clk_i);
      end
      if (!got && !feed_abort) fail_evt("wdat_accept_timeout");
    end
    wdat_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk_i);
      if (done_o) seen = 1'b1;
    end
    if (!seen) fail_evt(nm);
  endtask

  task automatic run_burst(input bit we, input logic [13:0] adr, input int len,
                           input logic [31:0] base, input bit toggle);
    push_exp(we, adr, len, base, 1'b1);
    issue_cmd(we, adr, len);
    if (we) feed(base, len, toggle);
    wait_done("done_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int start;
    bit hit;
    for (int i = 0; i < 16384; i++) begin ram[i] = 32'h0; exp_mem[i] = 32'h0; end
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_len_i = '0;
    wdat_i = '0; wdat_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_rdat_valid", {31'd0, rdat_valid_o}, 32'd0);
    chk("rst_rdat", rdat_o, 32'd0);
    chk("rst_wdat_ready", {31'd0, wdat_ready_o}, 32'd0);
    chk("rst_cyc", {31'd0, wb_bus.cyc}, 32'd0);
    chk("rst_stb", {31'd0, wb_bus.stb}, 32'd0);
    chk("rst_we", {31'd0, wb_bus.we}, 32'd0);
    chk("rst_adr", {18'd0, wb_bus.adr}, 32'd0);
    chk("rst_cti", {29'd0, wb_bus.cti}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // write burst 0x010, 4 words, ack every cycle
    run_burst(1'b1, 14'h010, 3, 32'hA0, 1'b0);
    @(negedge clk_i);
    for (int i = 0; i < 4; i++) chk("ram_wr_burst", ram[14'h010 + 14'(i)], 32'hA0 + 32'(i));

    // read back the same words through the master
    run_burst(1'b0, 14'h010, 3, 32'h0, 1'b0);
    @(negedge clk_i);

    // single classic write at the top word, address wraps
    run_burst(1'b1, 14'h3FFF, 0, 32'h5555_0001, 1'b0);
    chk("adr_wrap", {18'd0, wb_bus.adr}, 32'd0);
    @(negedge clk_i);
    chk("ram_single", ram[14'h3FFF], 32'h5555_0001);

    // 8-word write with toggled write valid and slave wait states
    ack_wait = 1'b1;
    run_burst(1'b1, 14'h100, 7, 32'hB0, 1'b1);
    @(negedge clk_i);
    for (int i = 0; i < 8; i++) chk("ram_toggle", ram[14'h100 + 14'(i)], 32'hB0 + 32'(i));
    run_burst(1'b0, 14'h100, 7, 32'h0, 1'b0);
    ack_wait = 1'b0;
    repeat (2) @(negedge clk_i);

    // reset on the 3rd beat of an 8-word write
    push_exp(1'b1, 14'h200, 7, 32'hC0, 1'b0);
    issue_cmd(1'b1, 14'h200, 7);
    start = mon_beats - 0;
    fork
      feed(32'hC0, 7, 1'b0);
      begin
        hit = 1'b0;
        for (int k = 0; k < 300 && !hit; k++) begin
          @(negedge clk_i);
          #2;
          if (mon_beats >= start + 3) hit = 1'b1;
        end
        if (!hit) fail_evt("third_beat_timeout");
        rst_i = 1'b1;
        #1;
        chk("rst_mid_cyc", {31'd0, wb_bus.cyc}, 32'd0);
        chk("rst_mid_stb", {31'd0, wb_bus.stb}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        exp_beat.delete();
        exp_done = 0;
        feed_abort = 1'b1;
      end
    join
    feed_abort = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("cmd_ready_after_rst", {31'd0, cmd_ready_o}, 32'd1);
    repeat (4) @(negedge clk_i);

    // command valid held high: two back-to-back 2-word reads
    push_exp(1'b0, 14'h100, 1, 32'h0, 1'b1);
    push_exp(1'b0, 14'h100, 1, 32'h0, 1'b1);
    issue_cmd(1'b0, 14'h100, 1);
    cmd_valid_i = 1'b1;
    issue_cmd(1'b0, 14'h100, 1);
    wait_done("done_timeout_hold");
    repeat (3) @(negedge clk_i);

    chk("beats_drained", exp_beat.size(), 32'd0);
    chk("rdat_drained", exp_rd.size(), 32'd0);
    chk("done_drained", exp_done, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
